led_blinker: RTL and testbench

- Free-running status-LED pattern generator on the system clock (27 MHz nominal).
- Drives four active-high LED outputs:
  - LED0 blinks at 0.5 Hz.
  - LED1 blinks at 1 Hz.
  - LED2 blinks at 2 Hz.
  - LED3 "breathes" via 8-bit PWM with a triangular duty ramp.
- No bus interface. It sits at top level as a heartbeat/alive indicator.

---
 rtl/led_blinker.sv | 130 +++++++++++++
 tb/tb_led_blinker.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/led_blinker.sv
// Heartbeat LED generator: three 50%-duty square waves at 0.5/1/2 Hz and one
// PWM "breathing" LED whose duty ramps 0..max..0 in a triangle.
module led_blinker #(
  parameter int unsigned CLK_FREQ_HZ = 27_000_000,
  parameter int unsigned PWM_BITS    = 8
) (
  input  logic i_sys_clk,
  input  logic i_rst,
  output logic o_led0,
  output logic o_led1,
  output logic o_led2,
  output logic o_led3
);

  localparam int unsigned Half0   = CLK_FREQ_HZ;
  localparam int unsigned Half1   = CLK_FREQ_HZ / 2;
  localparam int unsigned Half2   = CLK_FREQ_HZ / 4;
  localparam int unsigned DutyMax = (2 ** PWM_BITS) - 1;
  localparam int unsigned Step    = CLK_FREQ_HZ / DutyMax;

  localparam int unsigned W0 = $clog2(Half0);
  localparam int unsigned W1 = $clog2(Half1);
  localparam int unsigned W2 = $clog2(Half2);
  localparam int unsigned WS = $clog2(Step);

  typedef enum logic {StUp, StDown} dir_e;

  logic [W0-1:0]       cnt0_q, cnt0_d;
  logic [W1-1:0]       cnt1_q, cnt1_d;
  logic [W2-1:0]       cnt2_q, cnt2_d;
  logic [WS-1:0]       step_q, step_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  dir_e                dir_q, dir_d;
  logic                led0_q, led0_d;
  logic                led1_q, led1_d;
  logic                led2_q, led2_d;
  logic                led3_q, led3_d;
  logic                step_wrap;

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      cnt2_q <= '0;
      step_q <= '0;
      pwm_q  <= '0;
      duty_q <= '0;
      dir_q  <= StUp;
      led0_q <= 1'b0;
      led1_q <= 1'b0;
      led2_q <= 1'b0;
      led3_q <= 1'b0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      step_q <= step_d;
      pwm_q  <= pwm_d;
      duty_q <= duty_d;
      dir_q  <= dir_d;
      led0_q <= led0_d;
      led1_q <= led1_d;
      led2_q <= led2_d;
      led3_q <= led3_d;
    end
  end

  // Blink channels: toggle on the exact terminal count, then restart.
  always_comb begin
    cnt0_d = cnt0_q + W0'(1);
    cnt1_d = cnt1_q + W1'(1);
    cnt2_d = cnt2_q + W2'(1);
    led0_d = led0_q;
    led1_d = led1_q;
    led2_d = led2_q;
    if (cnt0_q == W0'(Half0 - 1)) begin
      cnt0_d = '0;
      led0_d = ~led0_q;
    end
    if (cnt1_q == W1'(Half1 - 1)) begin
      cnt1_d = '0;
      led1_d = ~led1_q;
    end
    if (cnt2_q == W2'(Half2 - 1)) begin
      cnt2_d = '0;
      led2_d = ~led2_q;
    end
  end

  // Breathing: duty moves one step per Step clocks; each endpoint is held for one step only.
  always_comb begin
    step_wrap = (step_q == WS'(Step - 1));
    step_d    = step_wrap ? '0 : step_q + WS'(1);
    pwm_d     = pwm_q + PWM_BITS'(1);
    duty_d    = duty_q;
    dir_d     = dir_q;
    if (step_wrap) begin
      unique case (dir_q)
        StUp: begin
          if (duty_q == PWM_BITS'(DutyMax)) begin
            duty_d = PWM_BITS'(DutyMax - 1);
            dir_d  = StDown;
          end else begin
            duty_d = duty_q + PWM_BITS'(1);
          end
        end
        StDown: begin
          if (duty_q == '0) begin
            duty_d = PWM_BITS'(1);
            dir_d  = StUp;
          end else begin
            duty_d = duty_q - PWM_BITS'(1);
          end
        end
        default: begin
          duty_d = '0;
          dir_d  = StUp;
        end
      endcase
    end
    led3_d = (pwm_q < duty_q);
  end

  assign o_led0 = led0_q;
  assign o_led1 = led1_q;
  assign o_led2 = led2_q;
  assign o_led3 = led3_q;

endmodule

// File: tb/tb_led_blinker.sv
// Directed bench for led_blinker at CLK_FREQ_HZ = 1024 (HALF 1024/512/256, STEP 4).
module tb_led_blinker;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic led0, led1, led2, led3;

  always #5 sys_clk = ~sys_clk;

  led_blinker #(
    .CLK_FREQ_HZ(1024),
    .PWM_BITS   (8)
  ) dut (
    .i_sys_clk(sys_clk),
    .i_rst    (rst),
    .o_led0   (led0),
    .o_led1   (led1),
    .o_led2   (led2),
    .o_led3   (led3)
  );

  int checks = 0;
  int passes = 0;
  int n;
  int rises[3];
  int highs[3];
  int first_rise[3];
  int led3_err, duty_err, led3_early, win_high;
  logic [2:0] prev;

  // Triangle of duty versus elapsed step count: 0..255 then 254..1, period 510.
  function automatic int tri_duty(input int s);
    int t;
    t = s % 510;
    return (t <= 255) ? t : 510 - t;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_stats();
    n = 0;
    led3_err = 0;
    duty_err = 0;
    led3_early = 0;
    win_high = 0;
    prev = '0;
    for (int c = 0; c < 3; c++) begin
      rises[c] = 0;
      highs[c] = 0;
      first_rise[c] = 0;
    end
  endtask

  // n counts clock edges since reset release; state is sampled just after edge n.
  task automatic run(input int ncyc);
    logic [2:0] cur;
    logic       exp3;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      n++;
      cur = {led2, led1, led0};
      for (int c = 0; c < 3; c++) begin
        if (cur[c] && !prev[c]) begin
          rises[c]++;
          if (first_rise[c] == 0) first_rise[c] = n;
        end
        if (cur[c]) highs[c]++;
      end
      prev = cur;
      exp3 = (((n - 1) % 256) < tri_duty((n - 1) / 4));
      if (led3 !== exp3) led3_err++;
      if (n <= 4 && led3) led3_early++;
      if (n >= 513 && n <= 768 && led3) win_high++;
      if (dut.duty_q !== 8'(tri_duty(n / 4))) duty_err++;
      if (n == 1020) chk("duty_peak", int'(dut.duty_q), 255);
      if (n == 1024) chk("duty_after_peak", int'(dut.duty_q), 254);
      if (n == 2040) chk("duty_floor", int'(dut.duty_q), 0);
      if (n == 2044) chk("duty_after_floor", int'(dut.duty_q), 1);
    end
  endtask

  initial begin
    clear_stats();
    rst = 1'b1;
    repeat (10) tick();
    chk("rst_led0", int'(led0), 0);
    chk("rst_led1", int'(led1), 0);
    chk("rst_led2", int'(led2), 0);
    chk("rst_led3", int'(led3), 0);
    chk("rst_duty", int'(dut.duty_q), 0);

    rst = 1'b0;
    clear_stats();
    run(8192);
    chk("rises_led0", rises[0], 4);
    chk("rises_led1", rises[1], 8);
    chk("rises_led2", rises[2], 16);
    chk("highs_led0", highs[0], 4096);
    chk("highs_led1", highs[1], 4096);
    chk("highs_led2", highs[2], 4096);
    chk("first_rise_led0", first_rise[0], 1024);
    chk("first_rise_led1", first_rise[1], 512);
    chk("first_rise_led2", first_rise[2], 256);
    chk("led3_duty0_low", led3_early, 0);
    // Duty ramps 128..191 within this window, so pwm < duty holds for pwm 0..169.
    chk("led3_window_high", win_high, 170);
    chk("led3_model", led3_err, 0);
    chk("duty_triangle", duty_err, 0);

    // Mid-run reset after edge 3000: led2 and led1 are high there, led0 low.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_stats();
    run(3000);
    chk("pre_rst_led0", int'(led0), 0);
    chk("pre_rst_led1", int'(led1), 1);
    chk("pre_rst_led2", int'(led2), 1);
    rst = 1'b1;
    tick();
    chk("midrst_led0", int'(led0), 0);
    chk("midrst_led1", int'(led1), 0);
    chk("midrst_led2", int'(led2), 0);
    chk("midrst_led3", int'(led3), 0);
    chk("midrst_duty", int'(dut.duty_q), 0);
    rst = 1'b0;
    clear_stats();
    run(600);
    chk("restart_first_rise_led2", first_rise[2], 256);
    chk("restart_first_rise_led1", first_rise[1], 512);
    chk("restart_rises_led2", rises[2], 1);
    chk("restart_led0_quiet", rises[0], 0);
    chk("restart_led3_model", led3_err, 0);
    chk("restart_duty", duty_err, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
